regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised register file for the pipelined RISC-V core: NRD combinational read ports,
//  one synchronous write port, and a per-register pending (busy) scoreboard. Sits in decode;
//  issue marks a destination pending, writeback clears it. Hazard/stall logic reads rd_busy.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of architectural registers (>=2)
//  NRD      2   number of read ports (>=1)
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never pending; 0: ordinary register
//  (local) AW = $clog2(NREGS), CW = $clog2(NREGS+1)
// PORTS
//  clk          in   1         clock, all state updates on posedge
//  rst_n        in   1         asynchronous active-low reset
//  rd_addr      in   NRD*AW    read addresses, port k = [k*AW +: AW]
//  rd_data      out  NRD*XLEN  read data, port k = [k*XLEN +: XLEN]
//  rd_busy      out  NRD       port k source register is pending
//  wr_en        in   1         writeback strobe
//  wr_addr      in   AW        writeback destination
//  wr_data      in   XLEN      writeback data
//  issue_en     in   1         instruction issued with destination issue_addr
//  issue_addr   in   AW        destination to mark pending
//  issue_busy   out  1         issue_addr already pending (WAW; stall issue)
//  flush        in   1         clear all pending bits (pipeline flush)
//  pending_cnt  out  CW        number of registers currently pending
// BEHAVIOUR
//  - Reset (async, rst_n=0): all registers = 0, all pending bits = 0, pending_cnt = 0;
//    rd_data reads 0 for every address, rd_busy = 0, issue_busy = 0.
//  - Read: combinational, zero latency; address >= NREGS returns 0, busy 0.
//  - Write: posedge clk with wr_en=1 stores wr_data; visible next cycle (see CONFIGURATION).
//    ZERO_REG=1 and wr_addr=0: data discarded. wr_addr >= NREGS: ignored.
//  - Scoreboard, per register r, next-state priority:
//      flush                          -> 0 (register data writes still performed)
//      issue_en & issue_addr==r       -> 1 (new producer wins over same-cycle writeback)
//      wr_en & wr_addr==r             -> 0
//      else hold. Issue to reg 0 with ZERO_REG=1 never sets pending.
//  - issue_en while issue_addr already pending is legal; bit stays 1; issue_busy flags it.
//  - pending_cnt: registered popcount of pending bits, updated the same edge as the bits;
//    range 0..NREGS, never wraps; equals popcount at all times (assertable invariant).
//  - rd_busy[k] = pending[rd_addr[k]] as registered state (no same-cycle writeback clear
//    unless bypass is compiled in).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-first bypass. If wr_en & wr_addr==rd_addr[k] (and not
//    reg 0 under ZERO_REG), rd_data[k]=wr_data and rd_busy[k]=0 in the same cycle;
//    issue_busy also sees the same-cycle clear.
//  Not defined: reads return stored value only; writeback visible one cycle later.
// STRUCTURE
//  Shared package regfile_pkg: localparam defaults (XLEN, NREGS), typedef reg_addr_t, and
//    function popcount used for assertion checks.
//  One sub-module: regfile_read_port (one mux + bypass + busy lookup), generated NRD times.
//  Storage, scoreboard bits and pending_cnt live in the top.
// TESTING
//  1 Reset mid-run: write x5=0xDEADBEEF, issue x7, assert rst_n=0 -> all rd_data=0,
//    rd_busy=0, pending_cnt=0 immediately, without waiting for clk.
//  2 Zero reg: wr_en addr 0 data 0x1234, issue addr 0 -> rd_data(0)=0, pending_cnt unchanged.
//  3 Issue x3 cycle N, wr x3=0xA5A5A5A5 cycle N+3 -> rd_busy=1 N+1..N+3, 0 from N+4;
//    data 0xA5A5A5A5 from N+4 (bypass: busy 0 and data valid in cycle N+3).
//  4 Same-cycle issue x9 and wr x9 -> x9 stays pending, data written, pending_cnt +1.
//  5 Issue x1..x31 on consecutive cycles -> pending_cnt = 31; flush -> 0 next cycle;
//    a wr concurrent with flush still updates the register.
//  6 NRD=3, XLEN=64 build: three ports read distinct regs in one cycle -> all correct;
//    re-issue of pending x4 -> issue_busy=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, register address type and a popcount helper for the register file.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);
   localparam int POP_MAX   = 256;

   typedef logic [AW_DEF-1:0] reg_addr_t;

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/regfile_read_port.sv
// One read port: register mux plus pending lookup, optional write-first bypass (REGFILE_BYPASS_EN).
// Latency: combinational, zero cycles.
// Backpressure: none; rd_busy is the stall hint for the consumer.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int AW       = $clog2(NREGS),
   parameter int ZERO_REG = 1
) (
   input  logic [NREGS-1:0][XLEN-1:0] regs,
   input  logic [NREGS-1:0]           pending,
   input  logic [AW-1:0]              rd_addr,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   output logic [XLEN-1:0]            rd_data,
   output logic                       rd_busy
);
   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      // Unmatched addresses (>= NREGS) fall through as data 0, not busy
      for (int r = 0; r < NREGS; r++) begin
         if (rd_addr == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
            rd_data = regs[r];
            rd_busy = pending[r];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rd_addr && 32'(rd_addr) < NREGS &&
          !(ZERO_REG != 0 && rd_addr == '0)) begin
         rd_data = wr_data;
         rd_busy = 1'b0;
      end
`endif
   end

`ifndef REGFILE_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard; REGFILE_BYPASS_EN adds write-first bypass.
// Latency: reads combinational; writes, issue marks and pending_cnt update on the next posedge.
// Backpressure: none taken; issue_busy/rd_busy report hazards for decode to stall on.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS),
   localparam int CW      = $clog2(NREGS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   output logic                issue_busy,
   input  logic                flush,
   output logic [CW-1:0]       pending_cnt
);
   logic [NREGS-1:0][XLEN-1:0] regs;
   logic [NREGS-1:0]           pending;
   logic [NREGS-1:0]           pending_nxt;
   logic [NREGS-1:0]           wr_hit;
   logic [NREGS-1:0]           iss_hit;
   logic [CW-1:0]              cnt_nxt;
   logic                       issue_busy_c;

   // Register 0 is excluded from both decodes when hardwired to zero
   always_comb begin
      wr_hit  = '0;
      iss_hit = '0;
      for (int r = 0; r < NREGS; r++) begin
         wr_hit[r]  = wr_en    && wr_addr    == AW'(r) && !(ZERO_REG != 0 && r == 0);
         iss_hit[r] = issue_en && issue_addr == AW'(r) && !(ZERO_REG != 0 && r == 0);
      end
   end

   // Flush beats issue, issue beats same-cycle writeback
   always_comb begin
      pending_nxt = pending;
      cnt_nxt     = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (flush)           pending_nxt[r] = 1'b0;
         else if (iss_hit[r]) pending_nxt[r] = 1'b1;
         else if (wr_hit[r])  pending_nxt[r] = 1'b0;
         cnt_nxt = cnt_nxt + CW'(pending_nxt[r]);
      end
   end

   always_comb begin
      issue_busy_c = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         if (issue_addr == AW'(r)) issue_busy_c = pending[r];
`ifdef REGFILE_BYPASS_EN
         if (issue_addr == AW'(r) && wr_hit[r]) issue_busy_c = 1'b0;
`endif
      end
   end
   assign issue_busy = issue_busy_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs        <= '0;
         pending     <= '0;
         pending_cnt <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_hit[r]) regs[r] <= wr_data;
         end
         pending     <= pending_nxt;
         pending_cnt <= cnt_nxt;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      regfile_read_port #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .AW       (AW),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .regs     (regs),
         .pending  (pending),
         .rd_addr  (rd_addr[k*AW +: AW]),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_data  (rd_data[k*XLEN +: XLEN]),
         .rd_busy  (rd_busy[k])
      );
   end

   a_cnt_matches_bits: assert property (@(posedge clk) disable iff (!rst_n)
      popcount(POP_MAX'(pending)) == 32'(pending_cnt));
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed checks of regfile_scoreboard against an array-based model.
module tb_regfile_scoreboard;
   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int NRD   = 3;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic                clk;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                issue_en;
   logic [AW-1:0]       issue_addr;
   logic                issue_busy;
   logic                flush;
   logic [CW-1:0]       pending_cnt;

   int total = 0;
   int bad   = 0;
   logic [63:0] mregs [NREGS];
   bit          mpend [NREGS];

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr), .issue_busy(issue_busy),
      .flush(flush), .pending_cnt(pending_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int mcount();
      int n = 0;
      foreach (mpend[i]) n += int'(mpend[i]);
      return n;
   endfunction

   function automatic logic [63:0] mread(input int a);
      logic [63:0] v;
      v = (a == 0) ? 64'd0 : mregs[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && int'(wr_addr) == a && a != 0) v = wr_data;
`endif
      return v;
   endfunction

   function automatic bit mbusy(input int a);
      bit b;
      b = mpend[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && int'(wr_addr) == a && a != 0) b = 1'b0;
`endif
      return b;
   endfunction

   task automatic model_reset();
      foreach (mregs[i]) begin
         mregs[i] = '0;
         mpend[i] = 1'b0;
      end
   endtask

   task automatic model_clock();
      if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
      if (flush) begin
         foreach (mpend[i]) mpend[i] = 1'b0;
      end else begin
         if (wr_en) mpend[wr_addr] = 1'b0;
         if (issue_en && issue_addr != 0) mpend[issue_addr] = 1'b1;
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NRD; k++) begin
         int a;
         a = int'(rd_addr[k*AW +: AW]);
         check($sformatf("rd_data%0d[x%0d]", k, a), rd_data[k*XLEN +: XLEN], mread(a));
         check($sformatf("rd_busy%0d[x%0d]", k, a), 64'(rd_busy[k]), 64'(mbusy(a)));
      end
      check("issue_busy", 64'(issue_busy), 64'(mbusy(int'(issue_addr))));
      check("pending_cnt", 64'(pending_cnt), 64'(mcount()));
   endtask

   task automatic drive(input bit we, input int wa, input logic [63:0] wd,
                        input bit ie, input int ia, input bit fl,
                        input int a0, input int a1, input int a2);
      wr_en      = we;
      wr_addr    = AW'(wa);
      wr_data    = wd;
      issue_en   = ie;
      issue_addr = AW'(ia);
      flush      = fl;
      rd_addr    = {AW'(a2), AW'(a1), AW'(a0)};
   endtask

   // Inputs are driven at negedge; outputs checked 1ns later; model advances at posedge
   task automatic cycle();
      #1 check_outputs();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   initial begin
      int cnt0;
      model_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
      #2 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset mid-run
      drive(1, 5, 64'hDEADBEEF, 1, 7, 0, 5, 7, 0);
      cycle();
      drive(0, 0, 0, 0, 7, 0, 5, 7, 0);
      #1 check_outputs();
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("rst_rd_data%0d", k), rd_data[k*XLEN +: XLEN], 64'd0);
         check($sformatf("rst_rd_busy%0d", k), 64'(rd_busy[k]), 64'd0);
      end
      check("rst_pending_cnt", 64'(pending_cnt), 64'd0);
      check("rst_issue_busy", 64'(issue_busy), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Register 0 ignores writes and issues
      drive(1, 0, 64'h1234, 1, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 check("x0_data", rd_data[63:0], 64'd0);
      check("x0_cnt", 64'(pending_cnt), 64'd0);
      cycle();

      // Issue x3, writeback three cycles later
      drive(0, 0, 0, 1, 3, 0, 3, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
      #1 check("x3_busy_n1", 64'(rd_busy[0]), 64'd1);
      cycle();
      cycle();
      drive(1, 3, 64'hA5A5A5A5, 0, 0, 0, 3, 0, 0);
`ifdef REGFILE_BYPASS_EN
      #1 check("x3_busy_n3", 64'(rd_busy[0]), 64'd0);
      check("x3_data_n3", rd_data[63:0], 64'hA5A5A5A5);
`else
      #1 check("x3_busy_n3", 64'(rd_busy[0]), 64'd1);
`endif
      cycle();
      drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
      #1 check("x3_busy_n4", 64'(rd_busy[0]), 64'd0);
      check("x3_data_n4", rd_data[63:0], 64'hA5A5A5A5);
      cycle();

      // Same-cycle issue and writeback: issue wins
      cnt0 = mcount();
      drive(1, 9, 64'h0909_0909_0909_0909, 1, 9, 0, 9, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 9, 0, 0);
      #1 check("x9_busy", 64'(rd_busy[0]), 64'd1);
      check("x9_data", rd_data[63:0], 64'h0909_0909_0909_0909);
      check("x9_cnt", 64'(pending_cnt), 64'(cnt0 + 1));
      cycle();

      // Fill the scoreboard, then flush with a concurrent write
      for (int i = 1; i < NREGS; i++) begin
         drive(0, 0, 0, 1, i, 0, i, 0, 0);
         cycle();
      end
      drive(1, 12, 64'hC0FFEE00_12121212, 0, 0, 1, 12, 4, 9);
      #1 check("full_cnt", 64'(pending_cnt), 64'd31);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 12, 4, 9);
      #1 check("flush_cnt", 64'(pending_cnt), 64'd0);
      check("flush_wr_x12", rd_data[63:0], 64'hC0FFEE00_12121212);
      cycle();

      // Three distinct reads in one cycle, then WAW re-issue of x4
      drive(1, 4, 64'h4444_0000_0000_4444, 0, 0, 0, 0, 0, 0);
      cycle();
      drive(1, 20, 64'h2020_2020_0000_0020, 1, 4, 0, 0, 0, 0);
      cycle();
      drive(1, 31, 64'h3131_0000_3131_0000, 0, 0, 0, 4, 20, 31);
      cycle();
      drive(0, 0, 0, 1, 4, 0, 4, 20, 31);
      #1 check("rd3_p0", rd_data[63:0], 64'h4444_0000_0000_4444);
      check("rd3_p1", rd_data[127:64], 64'h2020_2020_0000_0020);
      check("rd3_p2", rd_data[191:128], 64'h3131_0000_3131_0000);
      check("waw_issue_busy", 64'(issue_busy), 64'd1);
      cycle();

      // Random traffic, reads biased toward the write address to exercise bypass
      for (int n = 0; n < 600; n++) begin
         int wa, a0;
         wa = int'($urandom_range(0, NREGS - 1));
         a0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NREGS - 1));
         drive($urandom_range(0, 1) == 1, wa, {$urandom, $urandom},
               $urandom_range(0, 2) == 0, int'($urandom_range(0, NREGS - 1)),
               $urandom_range(0, 29) == 0,
               a0, int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
